pp_csa_accumulator: RTL and testbench

Sequential, parametrised partial-product reducer for the Wallace-tree multiplier datapath. Each beat it accepts three partial products with a common left shift and folds them into a running carry-save (sum, carry) pair with a 5:2 compressor built from three 3:2 full-adder layers. After the last beat, one carry-propagate add produces the final product, presented on a valid/ready output. Multiplier controllers use it to reduce wide or multi-pass products over several cycles instead of a fully unrolled tree.

---
 rtl/pp_csa_accumulator.sv | 129 ++++++++++++
 tb/tb_pp_csa_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_csa_accumulator.sv
// Purpose : multi-beat partial-product reducer; three operands per beat folded into a
//           carry-save (S, C) pair by a 5:2 compressor, one carry-propagate add at the end.
// Latency : result valid two cycles after the last beat is accepted.
// Backpr. : in_ready low from the last beat until the result handshake; the result is
//           held stable while out_valid && !out_ready.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready/in_last      beat handshake and end-of-operation marker
//   in_pp0..in_pp2, in_shift       three partial products and their common left shift
//   out_valid/out_ready            result handshake
//   out_data, out_beats, out_ovf   S + C, beats accumulated, forced end at MAX_BEATS
module pp_csa_accumulator #(
   parameter int WIDTH     = 32,
   parameter int IN_W      = 16,
   parameter int SHW       = 5,
   parameter int SIGNED    = 0,
   parameter int MAX_BEATS = 8,
   localparam int BCW      = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [IN_W-1:0]  in_pp0,
   input  logic [IN_W-1:0]  in_pp1,
   input  logic [IN_W-1:0]  in_pp2,
   input  logic [SHW-1:0]   in_shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [BCW-1:0]   out_beats,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, ACC, FINAL, OUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s_q, c_q;
   logic [BCW-1:0]   cnt_q;

   // Size cast of a signed value sign-extends; of an unsigned value zero-extends.
   function automatic logic [WIDTH-1:0] extend(input logic [IN_W-1:0] pp);
      if (SIGNED != 0) extend = WIDTH'($signed(pp));
      else             extend = WIDTH'(pp);
   endfunction

   // Full-adder carry vector, moved up one weight; the bit leaving the top is
   // worth 2^WIDTH and vanishes under modulo arithmetic.
   function automatic logic [WIDTH-1:0] carry(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
      logic [WIDTH-1:0] m;
      m     = (a & b) | (a & c) | (b & c);
      carry = {m[WIDTH-2:0], 1'b0};
   endfunction

   logic [WIDTH-1:0] p0, p1, p2;
   logic [WIDTH-1:0] base_s, base_c;
   logic [WIDTH-1:0] s1, c1, s2, c2, s_nx, c_nx;
   logic [BCW-1:0]   base_cnt, cnt_nx;
   logic             accept, at_max;

   always_comb begin
      p0 = extend(in_pp0) << in_shift;
      p1 = extend(in_pp1) << in_shift;
      p2 = extend(in_pp2) << in_shift;

      // A fresh operation starts from zero regardless of what the registers hold.
      base_s   = (state_q == IDLE) ? '0 : s_q;
      base_c   = (state_q == IDLE) ? '0 : c_q;
      base_cnt = (state_q == IDLE) ? '0 : cnt_q;

      s1   = p0 ^ p1 ^ p2;
      c1   = carry(p0, p1, p2);
      s2   = base_s ^ base_c ^ s1;
      c2   = carry(base_s, base_c, s1);
      s_nx = s2 ^ c1 ^ c2;
      c_nx = carry(s2, c1, c2);

      cnt_nx = base_cnt + BCW'(1);
      at_max = (cnt_nx == BCW'(MAX_BEATS));
   end

   assign in_ready  = (state_q == IDLE) || (state_q == ACC);
   assign out_valid = (state_q == OUT);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACC: begin
            if (accept) state_d = (in_last || at_max) ? FINAL : ACC;
         end
         FINAL:      state_d = OUT;
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         s_q       <= '0;
         c_q       <= '0;
         cnt_q     <= '0;
         out_data  <= '0;
         out_beats <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            s_q     <= s_nx;
            c_q     <= c_nx;
            cnt_q   <= cnt_nx;
            // Only the value written by the final beat survives into OUT.
            out_ovf <= at_max && !in_last;
         end
         if (state_q == FINAL) begin
            out_data  <= s_q + c_q;
            out_beats <= cnt_q;
         end
      end
   end

endmodule

// File: tb/tb_pp_csa_accumulator.sv
// Purpose : checks three configurations (unsigned/MB8, signed/MB8, unsigned/MB4) of the
//           reducer against an arithmetic model plus hand-computed literal results.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : out_ready per instance, held low in the backpressure scenario.
module tb_pp_csa_accumulator;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [2:0] iv, ordy, ir, ov, oo;
   logic       in_last;
   logic [7:0] pp0, pp1, pp2;
   logic [4:0] sh;
   logic [15:0] od0, od1, od2;
   logic [3:0] ob0, ob1;
   logic [2:0] ob2;

   pp_csa_accumulator #(.WIDTH(16), .IN_W(8), .SHW(5), .SIGNED(0), .MAX_BEATS(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_last(in_last),
      .in_pp0(pp0), .in_pp1(pp1), .in_pp2(pp2), .in_shift(sh),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_beats(ob0), .out_ovf(oo[0]));
   pp_csa_accumulator #(.WIDTH(16), .IN_W(8), .SHW(5), .SIGNED(1), .MAX_BEATS(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_last(in_last),
      .in_pp0(pp0), .in_pp1(pp1), .in_pp2(pp2), .in_shift(sh),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_beats(ob1), .out_ovf(oo[1]));
   pp_csa_accumulator #(.WIDTH(16), .IN_W(8), .SHW(5), .SIGNED(0), .MAX_BEATS(4)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_last(in_last),
      .in_pp0(pp0), .in_pp1(pp1), .in_pp2(pp2), .in_shift(sh),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_beats(ob2), .out_ovf(oo[2]));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int get_od(input int d);
      case (d)
         0:       get_od = int'(od0);
         1:       get_od = int'(od1);
         default: get_od = int'(od2);
      endcase
   endfunction

   function automatic int get_ob(input int d);
      case (d)
         0:       get_ob = int'(ob0);
         1:       get_ob = int'(ob1);
         default: get_ob = int'(ob2);
      endcase
   endfunction

   // ---------------- arithmetic model ----------------
   int mb [3] = '{8, 8, 4};
   bit sg [3] = '{1'b0, 1'b1, 1'b0};
   int acc [3];
   int nb [3];
   bit pend [3];
   int pd [3];
   int pb [3];
   bit po [3];
   bit prev_wait [3];

   function automatic int operand(input int d, input logic [7:0] p, input logic [4:0] s);
      int v;
      v = int'(p);
      if (sg[d] && p[7]) v = v - 256;
      operand = (v << s) & 32'hFFFF;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) begin
            acc[d] = 0; nb[d] = 0; pend[d] = 1'b0; prev_wait[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
               chk("mon_valid_has_result", longint'(pend[d]), 1);
               if (pend[d]) begin
                  chk("mon_data", get_od(d), pd[d]);
                  chk("mon_beats", get_ob(d), pb[d]);
                  chk("mon_ovf", longint'(oo[d]), longint'(po[d]));
               end
            end
            if (prev_wait[d]) chk("mon_valid_held", longint'(ov[d]), 1);
            chk("mon_in_ready", longint'(ir[d]), longint'(!pend[d]));
            prev_wait[d] = ov[d] && !ordy[d];
            if (ov[d] && ordy[d]) pend[d] = 1'b0;
            if (iv[d] && ir[d]) begin
               acc[d] = (acc[d] + operand(d, pp0, sh) + operand(d, pp1, sh)
                         + operand(d, pp2, sh)) & 32'hFFFF;
               nb[d]++;
               if (in_last || nb[d] == mb[d]) begin
                  pend[d] = 1'b1;
                  pd[d]   = acc[d];
                  pb[d]   = nb[d];
                  po[d]   = !in_last;
                  acc[d]  = 0;
                  nb[d]   = 0;
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // All drivers are called 1 time unit after a rising edge and return likewise.
   task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [4:0] s, input logic l);
      bit ok;
      ok = 1'b0;
      pp0 = a; pp1 = b; pp2 = c; sh = s; in_last = l;
      iv[d] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ir[d]) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         failures++;
         $display("FAIL send_timeout: dut %0d never ready", d);
      end else begin
         @(posedge clk); #1;
      end
      iv[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ov[d]) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL valid_timeout: dut %0d out_valid never rose", d);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_result(input int d, input int e_data, input int e_beats,
                              input int e_ovf, input string name);
      bit ok;
      ok = 1'b0;
      ordy[d] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ov[d]) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         failures++;
         $display("FAIL %s_timeout: dut %0d out_valid never rose", name, d);
      end else begin
         chk({name, "_data"}, get_od(d), e_data);
         chk({name, "_beats"}, get_ob(d), e_beats);
         chk({name, "_ovf"}, longint'(oo[d]), e_ovf);
      end
      @(posedge clk); #1;
      ordy[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; iv = '0; ordy = '0; in_last = 1'b0;
      pp0 = '0; pp1 = '0; pp2 = '0; sh = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_in_ready", longint'(ir), 7);
      chk("rst_out_valid", longint'(ov), 0);
      chk("rst_out_data", longint'({od0, od1, od2}), 0);
      chk("rst_out_beats", longint'({ob0, ob1, ob2}), 0);
      chk("rst_out_ovf", longint'(oo), 0);
      @(posedge clk); #1;

      // single beat and its latency
      send(0, 8'd3, 8'd5, 8'd7, 5'd0, 1'b1);
      @(negedge clk);
      chk("lat_final_cycle", longint'(ov[0]), 0);
      chk("lat_final_in_ready", longint'(ir[0]), 0);
      @(negedge clk);
      chk("lat_out_cycle", longint'(ov[0]), 1);
      @(posedge clk); #1;
      wait_result(0, 15, 1, 0, "one_beat");

      // two beats, second shifted by 8
      send(0, 8'hFF, 8'hFF, 8'hFF, 5'd0, 1'b0);
      send(0, 8'hFF, 8'hFF, 8'hFF, 5'd8, 1'b1);
      wait_result(0, 16'hFFFD, 2, 0, "two_beat");

      // sign extension versus zero extension
      send(1, 8'h80, 8'h01, 8'h00, 5'd0, 1'b1);
      wait_result(1, 16'hFF81, 1, 0, "signed");
      send(0, 8'h80, 8'h01, 8'h00, 5'd0, 1'b1);
      wait_result(0, 16'h0081, 1, 0, "unsigned");
      send(1, 8'hFF, 8'hFE, 8'h02, 5'd4, 1'b1);
      wait_result(1, 16'hFFF0, 1, 0, "signed_shift");

      // forced end at MAX_BEATS, then in_last on exactly the last beat
      for (int i = 0; i < 4; i++) send(2, 8'd1, 8'd0, 8'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("forced_in_ready", longint'(ir[2]), 0);
      @(posedge clk); #1;
      wait_result(2, 4, 4, 1, "forced");
      for (int i = 0; i < 3; i++) send(2, 8'd1, 8'd0, 8'd0, 5'd0, 1'b0);
      send(2, 8'd1, 8'd0, 8'd0, 5'd0, 1'b1);
      wait_result(2, 4, 4, 0, "last_at_max");

      // bubbles in ACC, then output backpressure with ignored input pulses
      send(0, 8'd2, 8'd3, 8'd4, 5'd1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      send(0, 8'd1, 8'd1, 8'd1, 5'd2, 1'b1);
      wait_valid(0);
      for (int i = 0; i < 5; i++) begin
         iv[0] = i[0]; pp0 = 8'hFF; pp1 = 8'hAA; pp2 = 8'h55; in_last = 1'b1;
         @(negedge clk);
         chk("bp_data", get_od(0), 30);
         chk("bp_valid", longint'(ov[0]), 1);
         chk("bp_in_ready", longint'(ir[0]), 0);
         @(posedge clk); #1;
      end
      iv[0] = 1'b0;
      wait_result(0, 30, 2, 0, "bubble_bp");
      @(negedge clk);
      chk("post_handshake_ready", longint'(ir[0]), 1);
      @(posedge clk); #1;

      // reset in the middle of an operation
      send(0, 8'd3, 8'd3, 8'd3, 5'd0, 1'b0);
      send(0, 8'd3, 8'd3, 8'd3, 5'd0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_data", get_od(0), 0);
      chk("midrst_beats", get_ob(0), 0);
      chk("midrst_valid", longint'(ov[0]), 0);
      chk("midrst_in_ready", longint'(ir[0]), 1);
      @(posedge clk); #1;
      send(0, 8'd1, 8'd1, 8'd1, 5'd0, 1'b1);
      wait_result(0, 3, 1, 0, "after_rst");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
